// File: rtl/shot_resolver.sv
// shot_resolver
//   Resolves one shot at a time against a player's board. For each accepted
//   shot it reads the board cell, marks it as shot, bumps the per-ship hit
//   counter and reports miss / hit / sunk / repeat. It also tracks sunk ships
//   and raises AllSunk once every ship is down.
//
// Parameters
//   NUM_SHIPS : ships in play (1..12); ship indices >= NUM_SHIPS act as water
//   SHIP_LEN  : packed 3-bit ship lengths, ship i at [3i+2:3i]
//
// Ports
//   Clock, Reset            : clock, synchronous active-high reset
//   FireValid/Row/Col       : shot request; accepted on FireValid & FireReady
//   FireReady               : resolver idle
//   BoardAddr, BoardData    : board RAM read port ({row,col}; 1-cycle latency)
//   BoardWE, BoardWData     : board RAM write port (marks cell as shot)
//   ShipWE, ShipIndex       : increment strobe / select for the hit-counter bank
//   ShipCounts              : all 12 hit counts, ship i at [3i+2:3i]
//   ResultValid             : one-cycle result strobe
//   Result, ResultShip      : 00 miss, 01 hit, 10 sunk, 11 repeat; ship index
//   AllSunk                 : level, every ship sunk (sticky until Reset)
//   ShotCount               : only with SHOT_COUNT_EN defined; saturating count
//                             of non-repeat shots
//
// Build option: define SHOT_COUNT_EN to add the ShotCount output.

module shot_resolver #(
  parameter int unsigned NUM_SHIPS = 12,
  parameter logic [35:0] SHIP_LEN  = 36'o2334_5223_3452
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        FireValid,
  input  logic [3:0]  FireRow,
  input  logic [3:0]  FireCol,
  output logic        FireReady,
  output logic [7:0]  BoardAddr,
  input  logic [4:0]  BoardData,
  output logic        BoardWE,
  output logic [4:0]  BoardWData,
  output logic        ShipWE,
  output logic [3:0]  ShipIndex,
  input  logic [35:0] ShipCounts,
  output logic        ResultValid,
  output logic [1:0]  Result,
  output logic [3:0]  ResultShip,
  output logic        AllSunk
`ifdef SHOT_COUNT_EN
  ,
  output logic [7:0]  ShotCount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVAL,
    S_CHECK,
    S_REPORT
  } state_t;

  typedef enum logic [1:0] {
    RES_MISS   = 2'b00,
    RES_HIT    = 2'b01,
    RES_SUNK   = 2'b10,
    RES_REPEAT = 2'b11
  } result_t;

  // Ships that can never be hit (out of play or zero length) start out sunk.
  function automatic logic [11:0] reset_sunk_mask();
    logic [11:0] m;
    m = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      if ((i >= NUM_SHIPS) || (SHIP_LEN[3*i +: 3] == 3'd0)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [11:0] SUNK_INIT = reset_sunk_mask();

  state_t      state_q,       state_d;
  logic [7:0]  addr_q,        addr_d;
  logic [3:0]  cell_q,        cell_d;
  result_t     result_q,      result_d;
  logic [3:0]  result_ship_q, result_ship_d;
  logic        result_valid_q, result_valid_d;
  logic        fire_ready_q,  fire_ready_d;
  logic [11:0] sunk_mask_q,   sunk_mask_d;
  logic        all_sunk_q,    all_sunk_d;
  logic [3:0]  ship_index_q,  ship_index_d;
`ifdef SHOT_COUNT_EN
  logic [7:0]  shot_count_q,  shot_count_d;
`endif

  // Decode of the board cell returned in EVAL.
  logic        rd_shot;
  logic [3:0]  rd_cell;
  logic        rd_in_range;
  logic        rd_sunk;

  // Per-ship lookups for the latched cell in CHECK.
  logic [2:0]  cur_count;
  logic [2:0]  cur_len;
  logic [11:0] cell_onehot;

  logic        board_we;
  logic [4:0]  board_wdata;
  logic        ship_we;

  assign rd_shot     = BoardData[4];
  assign rd_cell     = BoardData[3:0];
  assign rd_in_range = (32'(rd_cell) < NUM_SHIPS);

  always_comb begin
    rd_sunk     = 1'b0;
    cur_count   = '0;
    cur_len     = '0;
    cell_onehot = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      if ((rd_cell == 4'(i)) && (i < NUM_SHIPS)) begin
        rd_sunk = sunk_mask_q[i];
      end
      if (cell_q == 4'(i)) begin
        cur_count      = ShipCounts[3*i +: 3];
        cur_len        = SHIP_LEN[3*i +: 3];
        cell_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cell_d        = cell_q;
    result_d      = result_q;
    result_ship_d = result_ship_q;
    sunk_mask_d   = sunk_mask_q;
    all_sunk_d    = all_sunk_q;
    ship_index_d  = ship_index_q;
    board_we      = 1'b0;
    board_wdata   = '0;
    ship_we       = 1'b0;
`ifdef SHOT_COUNT_EN
    shot_count_d  = shot_count_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (FireValid) begin
          addr_d  = {FireRow, FireCol};
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        state_d = S_EVAL;
      end

      S_EVAL: begin
        cell_d = rd_cell;
        if (rd_shot || rd_sunk) begin
          result_d      = RES_REPEAT;
          result_ship_d = rd_cell;
          state_d       = S_REPORT;
        end else if (!rd_in_range) begin
          board_we      = 1'b1;
          board_wdata   = {1'b1, rd_cell};
          result_d      = RES_MISS;
          result_ship_d = 4'hF;
          state_d       = S_REPORT;
        end else begin
          board_we      = 1'b1;
          board_wdata   = {1'b1, rd_cell};
          ship_we       = 1'b1;
          ship_index_d  = rd_cell;
          state_d       = S_CHECK;
        end
      end

      S_CHECK: begin
        // The counter bank has already applied the EVAL increment.
        result_ship_d = cell_q;
        if (cur_count == cur_len) begin
          result_d    = RES_SUNK;
          sunk_mask_d = sunk_mask_q | cell_onehot;
          all_sunk_d  = all_sunk_q | (&(sunk_mask_q | cell_onehot));
        end else begin
          result_d    = RES_HIT;
        end
        state_d = S_REPORT;
      end

      S_REPORT: begin
`ifdef SHOT_COUNT_EN
        if ((result_q != RES_REPEAT) && (shot_count_q != 8'hFF)) begin
          shot_count_d = shot_count_q + 8'd1;
        end
`endif
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    result_valid_d = (state_d == S_REPORT);
    fire_ready_d   = (state_d == S_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      cell_q         <= '0;
      result_q       <= RES_MISS;
      result_ship_q  <= '0;
      result_valid_q <= 1'b0;
      fire_ready_q   <= 1'b1;
      sunk_mask_q    <= SUNK_INIT;
      all_sunk_q     <= 1'b0;
      ship_index_q   <= '0;
`ifdef SHOT_COUNT_EN
      shot_count_q   <= '0;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      cell_q         <= cell_d;
      result_q       <= result_d;
      result_ship_q  <= result_ship_d;
      result_valid_q <= result_valid_d;
      fire_ready_q   <= fire_ready_d;
      sunk_mask_q    <= sunk_mask_d;
      all_sunk_q     <= all_sunk_d;
      ship_index_q   <= ship_index_d;
`ifdef SHOT_COUNT_EN
      shot_count_q   <= shot_count_d;
`endif
    end
  end

  // Write strobes depend on the RAM data that only arrives in EVAL, and the
  // counter increment must land before CHECK, so they are decoded directly
  // from the EVAL state rather than registered. Reset suppresses them.
  assign BoardWE     = board_we & ~Reset;
  assign BoardWData  = BoardWE ? board_wdata : '0;
  assign ShipWE      = ship_we & ~Reset;
  assign ShipIndex   = ShipWE ? rd_cell : ship_index_q;

  assign FireReady   = fire_ready_q;
  assign BoardAddr   = addr_q;
  assign ResultValid = result_valid_q;
  assign Result      = result_q;
  assign ResultShip  = result_ship_q;
  assign AllSunk     = all_sunk_q;
`ifdef SHOT_COUNT_EN
  assign ShotCount   = shot_count_q;
`endif

endmodule

// File: tb/tb_shot_resolver.sv
// Testbench for shot_resolver: board RAM and hit-counter bank models around
// the default DUT, plus a NUM_SHIPS=6 instance sharing its inputs so the
// reduced-fleet AllSunk can be observed on the same shot sequence.
// Board layout: ship s occupies row s+4, columns 0..len(s)-1; (0,0) is an
// extra ship-0 cell, (1,5) holds out-of-range index 12, everything else water.

module tb_shot_resolver;

  localparam logic [1:0] MISS = 2'b00;
  localparam logic [1:0] HIT  = 2'b01;
  localparam logic [1:0] SUNK = 2'b10;
  localparam logic [1:0] REP  = 2'b11;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fire_valid;
  logic [3:0]  fire_row;
  logic [3:0]  fire_col;
  logic        fire_ready;
  logic [7:0]  board_addr;
  logic [4:0]  board_data;
  logic        board_we;
  logic [4:0]  board_wdata;
  logic        ship_we;
  logic [3:0]  ship_index;
  logic [35:0] ship_counts;
  logic        result_valid;
  logic [1:0]  result;
  logic [3:0]  result_ship;
  logic        all_sunk;

  logic        d6_fire_ready;
  logic [7:0]  d6_board_addr;
  logic        d6_board_we;
  logic [4:0]  d6_board_wdata;
  logic        d6_ship_we;
  logic [3:0]  d6_ship_index;
  logic        d6_result_valid;
  logic [1:0]  d6_result;
  logic [3:0]  d6_result_ship;
  logic        d6_all_sunk;
`ifdef SHOT_COUNT_EN
  logic [7:0]  shot_count;
  logic [7:0]  d6_shot_count;
`endif

  shot_resolver u_dut (
    .Clock(clk), .Reset(rst),
    .FireValid(fire_valid), .FireRow(fire_row), .FireCol(fire_col),
    .FireReady(fire_ready), .BoardAddr(board_addr), .BoardData(board_data),
    .BoardWE(board_we), .BoardWData(board_wdata),
    .ShipWE(ship_we), .ShipIndex(ship_index), .ShipCounts(ship_counts),
    .ResultValid(result_valid), .Result(result), .ResultShip(result_ship),
    .AllSunk(all_sunk)
`ifdef SHOT_COUNT_EN
    , .ShotCount(shot_count)
`endif
  );

  shot_resolver #(.NUM_SHIPS(6)) u_dut6 (
    .Clock(clk), .Reset(rst),
    .FireValid(fire_valid), .FireRow(fire_row), .FireCol(fire_col),
    .FireReady(d6_fire_ready), .BoardAddr(d6_board_addr), .BoardData(board_data),
    .BoardWE(d6_board_we), .BoardWData(d6_board_wdata),
    .ShipWE(d6_ship_we), .ShipIndex(d6_ship_index), .ShipCounts(ship_counts),
    .ResultValid(d6_result_valid), .Result(d6_result), .ResultShip(d6_result_ship),
    .AllSunk(d6_all_sunk)
`ifdef SHOT_COUNT_EN
    , .ShotCount(d6_shot_count)
`endif
  );

  int ship_len [12] = '{2, 5, 4, 3, 3, 2, 2, 5, 4, 3, 3, 2};

  // ---------------- board RAM model ----------------
  logic [4:0] board [256];
  logic       init_req;

  function automatic logic [4:0] init_cell(input int a);
    int r;
    int c;
    r = a / 16;
    c = a % 16;
    if (a == 0)       return 5'h00;
    if (a == 16 + 5)  return 5'h0C;
    if (r >= 4 && c < ship_len[r-4]) return {1'b0, 4'(r - 4)};
    return 5'h0F;
  endfunction

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) board[i] <= init_cell(i);
    end else if (board_we) begin
      board[board_addr] <= board_wdata;
    end
    board_data <= board[board_addr];
  end

  // ---------------- hit-counter bank model ----------------
  logic [2:0] cnt [12];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 12; i++) cnt[i] <= 3'd0;
    end else if (ship_we && ship_index < 4'd12) begin
      cnt[ship_index] <= cnt[ship_index] + 3'd1;
    end
  end

  always_comb begin
    ship_counts = '0;
    for (int i = 0; i < 12; i++) ship_counts[3*i +: 3] = cnt[i];
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    logic [1:0] res;
    logic [3:0] ship;
    int         lat;
    int         bwe;
    logic [4:0] wdata;
    int         swe;
    logic       all;
    logic       all6;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] c,
                              input logic [1:0] res, input logic [3:0] ship,
                              input int lat, input int bwe, input logic [4:0] wd,
                              input int swe, input logic all, input logic all6);
    vec_t v;
    v.row = r; v.col = c; v.res = res; v.ship = ship; v.lat = lat;
    v.bwe = bwe; v.wdata = wd; v.swe = swe; v.all = all; v.all6 = all6;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int         lat;
    int         nbwe;
    int         nswe;
    logic [4:0] wd;
    logic [3:0] sidx;
    logic [1:0] res;
    logic [3:0] ship;
    logic       all;
    logic       all6;
    lat = -1; nbwe = 0; nswe = 0; wd = '0; sidx = '0;
    res = '0; ship = '0; all = 1'b0; all6 = 1'b0;
    @(negedge clk);
    fire_valid = 1'b1; fire_row = v.row; fire_col = v.col;
    @(posedge clk);
    #1 fire_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) chk($sformatf("v%0d_addr", id), 32'(board_addr), 32'({v.row, v.col}));
      if (board_we) begin nbwe++; wd = board_wdata; end
      if (ship_we)  begin nswe++; sidx = ship_index; end
      if (result_valid) begin
        lat = k; res = result; ship = result_ship; all = all_sunk; all6 = d6_all_sunk;
        break;
      end
    end
    chk($sformatf("v%0d_latency", id), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_result", id), 32'(res), 32'(v.res));
    chk($sformatf("v%0d_ship", id), 32'(ship), 32'(v.ship));
    chk($sformatf("v%0d_board_we_cnt", id), 32'(nbwe), 32'(v.bwe));
    if (v.bwe != 0) chk($sformatf("v%0d_wdata", id), 32'(wd), 32'(v.wdata));
    chk($sformatf("v%0d_ship_we_cnt", id), 32'(nswe), 32'(v.swe));
    if (v.swe != 0) chk($sformatf("v%0d_ship_index", id), 32'(sidx), 32'(v.ship));
    chk($sformatf("v%0d_all_sunk", id), 32'(all), 32'(v.all));
    chk($sformatf("v%0d_all_sunk6", id), 32'(all6), 32'(v.all6));
    @(negedge clk);
    chk($sformatf("v%0d_valid_drop", id), 32'(result_valid), 32'd0);
    chk($sformatf("v%0d_ready", id), 32'(fire_ready), 32'd1);
    chk($sformatf("v%0d_result_held", id), 32'(result), 32'(v.res));
  endtask

  vec_t vecs[$];

  initial begin
    int rv_seen;
    int we_seen;

    rst = 1'b1; init_req = 1'b1; fire_valid = 1'b0; fire_row = '0; fire_col = '0;

    // Stimulus table: first hand-picked corner shots, then sink ships 1..11.
    vecs.push_back(mk(4'd2, 4'd3, MISS, 4'hF, 3, 1, 5'h1F, 0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd2, 4'd3, REP,  4'hF, 3, 0, 5'h00, 0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd4, 4'd0, HIT,  4'h0, 4, 1, 5'h10, 1, 1'b0, 1'b0));
    vecs.push_back(mk(4'd4, 4'd1, SUNK, 4'h0, 4, 1, 5'h10, 1, 1'b0, 1'b0));
    vecs.push_back(mk(4'd4, 4'd0, REP,  4'h0, 3, 0, 5'h00, 0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd0, 4'd0, REP,  4'h0, 3, 0, 5'h00, 0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd1, 4'd5, MISS, 4'hF, 3, 1, 5'h1C, 0, 1'b0, 1'b0));
    for (int s = 1; s < 12; s++) begin
      for (int c = 0; c < ship_len[s]; c++) begin
        logic last;
        last = (c == ship_len[s] - 1);
        vecs.push_back(mk(4'(s + 4), 4'(c), last ? SUNK : HIT, 4'(s), 4, 1,
                          {1'b1, 4'(s)}, 1, (s == 11) && last,
                          (s > 5) || ((s == 5) && last)));
      end
    end
    vecs.push_back(mk(4'd2, 4'd4, MISS, 4'hF, 3, 1, 5'h1F, 0, 1'b1, 1'b1));

    repeat (3) @(negedge clk);
    rst = 1'b0; init_req = 1'b0;
    @(negedge clk);
    chk("rst_ready",        32'(fire_ready),   32'd1);
    chk("rst_addr",         32'(board_addr),   32'd0);
    chk("rst_board_we",     32'(board_we),     32'd0);
    chk("rst_board_wdata",  32'(board_wdata),  32'd0);
    chk("rst_ship_we",      32'(ship_we),      32'd0);
    chk("rst_ship_index",   32'(ship_index),   32'd0);
    chk("rst_valid",        32'(result_valid), 32'd0);
    chk("rst_result",       32'(result),       32'd0);
    chk("rst_result_ship",  32'(result_ship),  32'd0);
    chk("rst_all_sunk",     32'(all_sunk),     32'd0);
    chk("rst_all_sunk6",    32'(d6_all_sunk),  32'd0);
`ifdef SHOT_COUNT_EN
    chk("rst_shot_count",   32'(shot_count),   32'd0);
`endif

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Every counter must have stopped exactly at its ship length.
    for (int s = 0; s < 12; s++)
      chk($sformatf("final_count%0d", s), 32'(cnt[s]), 32'(ship_len[s]));

    // Reset while idle with every ship sunk, then reload the board.
    @(negedge clk);
    rst = 1'b1; init_req = 1'b1;
    @(negedge clk);
    rst = 1'b0; init_req = 1'b0;
    @(negedge clk);
    chk("reset2_ready",     32'(fire_ready),  32'd1);
    chk("reset2_all_sunk",  32'(all_sunk),    32'd0);
    chk("reset2_all_sunk6", 32'(d6_all_sunk), 32'd0);

    // Reset asserted during CHECK of a ship-0 hit.
    @(negedge clk);
    fire_valid = 1'b1; fire_row = 4'd4; fire_col = 4'd0;
    @(posedge clk);
    #1 fire_valid = 1'b0;
    @(negedge clk);                       // LOOKUP
    @(negedge clk);                       // EVAL
    chk("abort_eval_ship_we", 32'(ship_we), 32'd1);
    @(negedge clk);                       // CHECK
    chk("abort_check_valid", 32'(result_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready",     32'(fire_ready), 32'd1);
    chk("abort_all_sunk",  32'(all_sunk),   32'd0);
    chk("abort_count0",    32'(cnt[0]),     32'd0);
    rv_seen = 0; we_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
      if (board_we || ship_we) we_seen++;
    end
    chk("abort_no_valid",  32'(rv_seen), 32'd0);
    chk("abort_no_writes", 32'(we_seen), 32'd0);

    // SunkMask was cleared: ship 0's extra cell is a hit again; (4,0) was
    // marked in EVAL before the abort so it repeats.
    run_vec(mk(4'd0, 4'd0, HIT,  4'h0, 4, 1, 5'h10, 1, 1'b0, 1'b0), 100);
    run_vec(mk(4'd4, 4'd0, REP,  4'h0, 3, 0, 5'h00, 0, 1'b0, 1'b0), 101);
    run_vec(mk(4'd4, 4'd1, SUNK, 4'h0, 4, 1, 5'h10, 1, 1'b0, 1'b0), 102);
    run_vec(mk(4'd2, 4'd3, MISS, 4'hF, 3, 1, 5'h1F, 0, 1'b0, 1'b0), 103);
    run_vec(mk(4'd2, 4'd4, MISS, 4'hF, 3, 1, 5'h1F, 0, 1'b0, 1'b0), 104);
    run_vec(mk(4'd2, 4'd5, MISS, 4'hF, 3, 1, 5'h1F, 0, 1'b0, 1'b0), 105);

`ifdef SHOT_COUNT_EN
    // 2 hits/sinks + 1 repeat + 3 misses since the last reset.
    chk("shot_count_5", 32'(shot_count), 32'd5);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); init_req = 1'b1;
      @(negedge clk); init_req = 1'b0;
      run_vec(mk(4'd2, 4'd3, MISS, 4'hF, 3, 1, 5'h1F, 0, 1'b0, 1'b0), 200 + n);
    end
    chk("shot_count_sat", 32'(shot_count), 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
